// File: rtl/wb_io_pkg.sv
// Shared constants for the Wishbone GPIO bridge: register offsets (word index),
// output-enable reset level and legal synchroniser depths.
package wb_io_pkg;

  localparam logic [2:0] OFS_OUT      = 3'd0;
  localparam logic [2:0] OFS_OEB      = 3'd1;
  localparam logic [2:0] OFS_IN       = 3'd2;
  localparam logic [2:0] OFS_IRQ_EN   = 3'd3;
  localparam logic [2:0] OFS_IRQ_STAT = 3'd4;
  localparam logic [2:0] OFS_EDGE     = 3'd5;

  localparam logic OEB_RST = 1'b1;

  localparam int unsigned SYNC_MIN = 2;
  localparam int unsigned SYNC_MAX = 3;

endpackage

// File: rtl/io_sync_edge.sv
// Per-bit multi-flop input synchroniser followed by one history flop for
// rising/falling edge detection.
module io_sync_edge #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      prev_q <= '0;
    end else begin
      stage_q[0] <= din;
      for (int unsigned k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
      prev_q <= stage_q[DEPTH-1];
    end
  end

  assign sync = stage_q[DEPTH-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/wb_io_bridge.sv
// Wishbone-slave GPIO bridge: OUT/OEB/IN registers plus per-pad edge interrupts.
// Optional LA_OVERRIDE_EN adds logic-analyser pad override ports.
module wb_io_bridge
  import wb_io_pkg::*;
#(
  parameter int unsigned NUM_IO      = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_FF00,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic [2:0]        user_irq
`ifdef LA_OVERRIDE_EN
  ,
  input  logic [NUM_IO-1:0] la_data_in,
  input  logic [NUM_IO-1:0] la_oenb
`endif
);

  localparam int unsigned DEPTH = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN :
                                  (SYNC_STAGES > SYNC_MAX) ? SYNC_MAX : SYNC_STAGES;

  logic [NUM_IO-1:0] out_q, oeb_q, irq_en_q, irq_stat_q, edge_sel_q;
  logic              ack_q, irq_q;
  logic [31:0]       dat_q;

  logic              hit, acc, wr_stb;
  logic [2:0]        ofs;
  logic [31:0]       wmask32;
  logic [NUM_IO-1:0] wmask, wdata, w1c, rd_io;
  logic [NUM_IO-1:0] sync, rise, fall, edge_hit;

  assign hit     = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign acc     = hit & ~ack_q;
  assign wr_stb  = acc & wbs_we_i;
  assign ofs     = wbs_adr_i[4:2];
  assign wmask32 = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wmask   = NUM_IO'(wmask32);
  assign wdata   = NUM_IO'(wbs_dat_i) & wmask;
  assign w1c     = (wr_stb && ofs == OFS_IRQ_STAT) ? wdata : '0;

  io_sync_edge #(
    .WIDTH (NUM_IO),
    .DEPTH (DEPTH)
  ) u_sync (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .din  (io_in),
    .sync (sync),
    .rise (rise),
    .fall (fall)
  );

  assign edge_hit = (edge_sel_q & rise) | (~edge_sel_q & fall);

  function automatic logic [NUM_IO-1:0] merge(input logic [NUM_IO-1:0] old);
    return (old & ~wmask) | wdata;
  endfunction

  always_comb begin
    rd_io = '0;
    case (ofs)
      OFS_OUT:      rd_io = out_q;
      OFS_OEB:      rd_io = oeb_q;
      OFS_IN:       rd_io = sync;
      OFS_IRQ_EN:   rd_io = irq_en_q;
      OFS_IRQ_STAT: rd_io = irq_stat_q;
      OFS_EDGE:     rd_io = edge_sel_q;
      default:      rd_io = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      out_q      <= '0;
      oeb_q      <= {NUM_IO{OEB_RST}};
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      edge_sel_q <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      ack_q <= acc;
      dat_q <= (acc && !wbs_we_i) ? 32'(rd_io) : '0;
      irq_q <= |(irq_stat_q & irq_en_q);
      // A new edge overrides a simultaneous write-one-to-clear.
      irq_stat_q <= (irq_stat_q & ~w1c) | edge_hit;
      if (wr_stb) begin
        case (ofs)
          OFS_OUT:    out_q      <= merge(out_q);
          OFS_OEB:    oeb_q      <= merge(oeb_q);
          OFS_IRQ_EN: irq_en_q   <= merge(irq_en_q);
          OFS_EDGE:   edge_sel_q <= merge(edge_sel_q);
          default:    ;
        endcase
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign user_irq  = {2'b00, irq_q};

`ifdef LA_OVERRIDE_EN
  assign io_out = (out_q & la_oenb) | (la_data_in & ~la_oenb);
  assign io_oeb = oeb_q & la_oenb;
`else
  assign io_out = out_q;
  assign io_oeb = oeb_q;
`endif

  // Bus bits beyond NUM_IO (or register bits beyond the 32-bit bus) are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{wbs_dat_i, wmask32, rd_io};

endmodule

// File: doc/wb_io_bridge.md
Name: wb_io_bridge

Overview:
Parametrised Wishbone-slave GPIO bridge between the management SoC bus and the user IO pads, generalising the fixed 32-pad direct pass-through.
- Provides memory-mapped output, output-enable and synchronised input registers for NUM_IO pads.
- Provides per-pad edge-detect interrupts on user_irq[0].
- Sits inside the user project wrapper, alongside the game core.

Parameters:
NUM_IO, 32, number of managed pads (1..38); bits above NUM_IO-1 read 0, writes ignored
BASE_ADDR, 32'h3000_0000, Wishbone base address of the register window
ADDR_MASK, 32'hFFFF_FF00, address bits compared against BASE_ADDR for decode
SYNC_STAGES, 2, input synchroniser depth (2..3)

Ports:
wb_clk_i  input  1  sole clock
wb_rst_i  input  1  synchronous active-high reset
wbs_cyc_i  input  1  bus cycle
wbs_stb_i  input  1  strobe
wbs_we_i  input  1  write enable
wbs_sel_i  input  4  byte lane select
wbs_adr_i  input  32  byte address
wbs_dat_i  input  32  write data
wbs_ack_o  output  1  acknowledge
wbs_dat_o  output  32  read data
io_in  input  NUM_IO  pad inputs (asynchronous)
io_out  output  NUM_IO  pad output values
io_oeb  output  NUM_IO  pad output enables, active low
user_irq  output  3  interrupts; [2:1] tied 0
la_data_in  input  NUM_IO  LA drive values (LA_OVERRIDE_EN only)
la_oenb  input  NUM_IO  LA enables, active low (LA_OVERRIDE_EN only)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (wb_clk_i / wb_rst_i).
- Reset values: OUT=0, OEB=all 1 (all pads inputs), IRQ_EN=0, IRQ_STAT=0, EDGE_SEL=0, ack=0, dat_o=0, synchroniser flops=0, user_irq=0.
- Decode: hit = cyc & stb & ((adr & ADDR_MASK) == BASE_ADDR). Offset = adr[4:2].
- Register map:
  - 0x00 OUT, RW
  - 0x04 OEB, RW
  - 0x08 IN, RO, synchronised pads
  - 0x0C IRQ_EN, RW
  - 0x10 IRQ_STAT, W1C
  - 0x14 EDGE_SEL, RW; 1 = rising, 0 = falling
  - 0x18..0x1C: read 0, writes ignored, still acked
- Handshake:
  - ack rises exactly 1 cycle after a hit while ack=0; it is a one-cycle pulse.
  - A strobe held across cycles gets exactly one ack per two cycles (ack gated by !ack).
  - A non-hit never acks.
  - dat_o is valid in the ack cycle and is 0 otherwise.
- Writes: commit on the ack edge, per byte lane via wbs_sel_i. sel=0 acks with no change.
- Input path: SYNC_STAGES-deep flops feed IN, then one further delay flop (prev) for edge detection.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Edge-to-IRQ_STAT latency = SYNC_STAGES+1 cycles.
- IRQ_STAT[i] sets on the selected edge regardless of IRQ_EN.
  - W1C clears, but a set in the same cycle wins.
  - Changing EDGE_SEL does not generate a spurious edge.
- user_irq[0] = |(IRQ_STAT & IRQ_EN), registered (+1 cycle).
- io_out = OUT and io_oeb = OEB, both direct from registers.
- Reset mid-transaction: the ack is dropped; the master must reissue.

Optional Feature:
- Macro: LA_OVERRIDE_EN.
- When defined:
  - The la_data_in and la_oenb ports exist.
  - For each pad with la_oenb[i]=0: io_out[i]=la_data_in[i] and io_oeb[i]=0 (LA forces the pad to drive).
  - Bus registers are unchanged and read back their own values.
- When undefined: the LA ports are absent and io_out/io_oeb come purely from the registers.

Decomposition:
- Package wb_io_pkg holds:
  - register offset constants (OFS_OUT..OFS_EDGE)
  - the OEB reset constant
  - the SYNC_STAGES range limits
- One sub-module, io_sync_edge: per-bit synchroniser plus rise/fall detect, parametrised by width and depth.

Test Plan:
- Reset, then read 0x04 -> dat_o=all ones (masked to NUM_IO); read 0x00 -> 0; user_irq=0.
- Write 0x00=0xA5A5_A5A5 with sel=4'b0011, then read -> 0x0000_A5A5; io_out matches; ack exactly 1 cycle after stb.
- Set EDGE_SEL[3]=1, IRQ_EN[3]=1, then pulse io_in[3] 0->1 -> IRQ_STAT=0x8 after SYNC_STAGES+1 cycles; user_irq[0]=1 one cycle later; write 0x10=0x8 -> user_irq[0]=0.
- Drive a rising edge on bit 3 in the same cycle as its W1C -> IRQ_STAT[3] remains 1.
- Address 0x3000_0100 (outside mask) -> no ack, no register change; hold stb 4 cycles on a hit -> exactly 2 ack pulses.
- With LA_OVERRIDE_EN: la_oenb[0]=0, la_data_in[0]=1, OUT=0, OEB=1 -> io_out[0]=1, io_oeb[0]=0; a read of 0x04 still returns 1.
